mem_arbiter: RTL

- Shares the single SRAM-like memory port between the instruction-fetch side (F stage) and the data side (M stage) of the 5-stage MIPS pipeline.
- Sequences one outstanding transaction at a time: grant, address handshake, then data return.
- Buffers each side's returned word until the pipeline advances.
- Generates the inst_stall / data_stall signals consumed by the hazard unit.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_respbuf.sv | 30 +++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } arbState_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } arbOwner_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_arb_respbuf.sv
// One-word response buffer with a valid flag. Clear wins over set; a set
// with drop asserted leaves both the flag and the word untouched.
module mem_arb_respbuf (
  input  logic        clk,
  input  logic        rst,
  input  logic        set,
  input  logic        clr,
  input  logic        drop,
  input  logic [31:0] wdata,
  output logic        vld,
  output logic [31:0] rdata
);

  logic capture;

  assign capture = set & ~drop;

  // valid flag and buffered word
  always_ff @(posedge clk) begin
    if (rst) begin
      vld   <= 1'b0;
      rdata <= 32'h0;
    end else begin
      if (clr)          vld <= 1'b0;
      else if (capture) vld <= 1'b1;
      if (capture) rdata <= wdata;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between the fetch and data sides,
// one outstanding transaction at a time, and produces the pipeline stalls.
// Optional macro MEM_ARB_PERF_CNT_EN adds saturating stall-cycle counters.
//
// state | meaning
// IDLE  | no transaction; grant an eligible side (req set, buffer empty)
// ADDR  | mem_req held with latched fields until mem_addr_ok
// WAIT  | address accepted; waiting for mem_data_ok
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
`ifdef MEM_ARB_PERF_CNT_EN
  parameter int CNT_W     = 32,
`endif
  parameter bit INST_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [31:0]       inst_rdata,
  output logic              inst_stall,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_stall,
`ifdef MEM_ARB_PERF_CNT_EN
  output logic [CNT_W-1:0]  inst_stall_cnt,
  output logic [CNT_W-1:0]  data_stall_cnt,
`endif
  input  logic              ext_stall,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [31:0]       mem_rdata
);

  arbState_t state, stateNext;
  arbOwner_t own;
  logic      instVld, dataVld;
  logic      instElig, dataElig;
  logic      grantInst, grantData;
  logic      memDone, pipeRelease;
  logic      instBusy, dropReg, dropEff;

  assign instElig    = inst_req & ~instVld;
  assign dataElig    = data_req & ~dataVld;
  assign memDone     = (state == WAIT) & mem_data_ok;
  assign inst_stall  = inst_req & ~instVld;
  assign data_stall  = data_req & ~dataVld;
  assign pipeRelease = ~ext_stall & ~inst_stall & ~data_stall;
  assign instBusy    = (own == OWN_INST) & (state != IDLE);
  // a flush landing on the return cycle itself must also discard the word
  assign dropEff     = dropReg | (flush & instBusy);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // next state, grant decision and downstream request
  always_comb begin
    stateNext = state;
    grantInst = 1'b0;
    grantData = 1'b0;
    mem_req   = 1'b0;
    case (state)
      IDLE: begin
        if (instElig && (!dataElig || INST_PRIO)) grantInst = 1'b1;
        else if (dataElig)                        grantData = 1'b1;
        if (grantInst || grantData) stateNext = ADDR;
      end
      ADDR: begin
        mem_req = 1'b1;
        if (mem_addr_ok) stateNext = WAIT;
      end
      WAIT: begin
        if (mem_data_ok) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // latch the granted side's request fields and owner
  always_ff @(posedge clk) begin
    if (rst) begin
      own       <= OWN_INST;
      mem_wr    <= 1'b0;
      mem_size  <= SIZE_BYTE;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
    end else if (grantInst) begin
      own       <= OWN_INST;
      mem_wr    <= 1'b0;
      mem_size  <= SIZE_WORD;
      mem_addr  <= inst_addr;
      mem_wdata <= 32'h0;
    end else if (grantData) begin
      own       <= OWN_DATA;
      mem_wr    <= data_wr;
      mem_size  <= data_size;
      mem_addr  <= data_addr;
      mem_wdata <= data_wdata;
    end
  end

  // remember that an in-flight fetch was flushed
  always_ff @(posedge clk) begin
    if (rst)                    dropReg <= 1'b0;
    else if (memDone)           dropReg <= 1'b0;
    else if (flush && instBusy) dropReg <= 1'b1;
  end

  mem_arb_respbuf uInstBuf (
    .clk   (clk),
    .rst   (rst),
    .set   (memDone & (own == OWN_INST)),
    .clr   (pipeRelease | flush),
    .drop  (dropEff),
    .wdata (mem_rdata),
    .vld   (instVld),
    .rdata (inst_rdata)
  );

  mem_arb_respbuf uDataBuf (
    .clk   (clk),
    .rst   (rst),
    .set   (memDone & (own == OWN_DATA)),
    .clr   (pipeRelease),
    .drop  (1'b0),
    .wdata (mem_rdata),
    .vld   (dataVld),
    .rdata (data_rdata)
  );

`ifdef MEM_ARB_PERF_CNT_EN
  // saturating stall-cycle counters
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_stall_cnt <= '0;
      data_stall_cnt <= '0;
    end else begin
      if (inst_stall && !(&inst_stall_cnt)) inst_stall_cnt <= inst_stall_cnt + CNT_W'(1);
      if (data_stall && !(&data_stall_cnt)) data_stall_cnt <= data_stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
